// File: rtl/Types.sv
// Shared types for the rename stage: register-index widths, decode/rename
// instruction records, and the allocation predicate.
package Types;

   localparam int NUM_AREGS       = 32;
   localparam int NUM_PREGS       = 128;
   localparam int FREE_LIST_DEPTH = 96;

   localparam int AREG_W = $clog2(NUM_AREGS);
   localparam int PREG_W = $clog2(NUM_PREGS);
   localparam int CNT_W  = $clog2(FREE_LIST_DEPTH + 1);

   typedef logic [AREG_W-1:0] a_reg;
   typedef logic [PREG_W-1:0] p_reg;

   typedef struct packed {
      logic [31:0] immediate;
      logic [3:0]  ALUOp;
      logic        ALUSrc;
      logic        RegWrite;
      logic        MemRead;
      logic        MemWrite;
      logic        MemtoReg;
      a_reg        ARegAddrSrc0;
      a_reg        ARegAddrSrc1;
      a_reg        ARegAddrDst;
   } decode_struct;

   typedef struct packed {
      logic [31:0] immediate;
      logic [3:0]  ALUOp;
      logic        ALUSrc;
      logic        RegWrite;
      logic        MemRead;
      logic        MemWrite;
      logic        MemtoReg;
      p_reg        PRegAddrSrc0;
      p_reg        PRegAddrSrc1;
      p_reg        PRegAddrDst;
      p_reg        OldPRegAddrDst;
   } rename_struct;

   // Writes to x0 are architecturally discarded, so they never take a p-reg.
   function automatic logic needs_alloc(input decode_struct d);
      return d.RegWrite && (d.ARegAddrDst != '0);
   endfunction

endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical registers, seeded at reset with the
// p-regs not covered by the identity RAT mapping.
module free_list
   import Types::*;
#(
   parameter int DEPTH = FREE_LIST_DEPTH,
   parameter int BASE  = NUM_AREGS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  p_reg             i_push_preg,
   input  logic             i_pop,
   output p_reg             o_head,
   output logic [CNT_W-1:0] o_count
);

   localparam logic [CNT_W-1:0] L_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] L_LAST = CNT_W'(DEPTH - 1);

   p_reg             r_mem [DEPTH];
   logic [CNT_W-1:0] r_head;
   logic [CNT_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic             w_push_ok;

   function automatic logic [CNT_W-1:0] next_ptr(input logic [CNT_W-1:0] p);
      return (p == L_LAST) ? '0 : p + CNT_W'(1);
   endfunction

   // A push into a full list is illegal; it is dropped rather than corrupting state.
   assign w_push_ok = i_push && (r_count != L_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= p_reg'(BASE + i);
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= L_FULL;
      end else begin
         if (w_push_ok) begin
            r_mem[r_tail] <= i_push_preg;
            r_tail        <= next_ptr(r_tail);
         end
         if (i_pop) r_head <= next_ptr(r_head);
         case ({w_push_ok, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_head];
   assign o_count = r_count;

   a_push_full: assert property (@(posedge clk) disable iff (!rst_n)
                                 !(i_push && (r_count == L_FULL)));
   a_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
                                 !(i_pop && (r_count == '0)));

endmodule

// File: rtl/rename_stage.sv
// Register rename stage: RAT lookup, destination allocation from the free
// list, and a one-entry registered output with valid/ready handshake.
module rename_stage
   import Types::*;
#(
   parameter int NUM_PREGS = Types::NUM_PREGS,
   parameter int NUM_AREGS = Types::NUM_AREGS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  decode_struct     in_decode,
   output logic             out_valid,
   input  logic             out_ready,
   output rename_struct     out_rename,
   input  logic             free_valid,
   input  p_reg             free_preg,
   output logic [CNT_W-1:0] free_count
);

   p_reg         r_rat [NUM_AREGS];
   logic         r_out_valid;
   rename_struct r_out;

   logic         w_alloc;
   logic         w_accept;
   logic         w_pop;
   p_reg         w_head;
   p_reg         w_src0;
   p_reg         w_src1;
   p_reg         w_old_dst;
   rename_struct w_next;

   assign w_alloc  = needs_alloc(in_decode);
   assign in_ready = (!r_out_valid || out_ready) && (!w_alloc || (free_count != '0));
   assign w_accept = in_valid && in_ready;
   assign w_pop    = w_accept && w_alloc;

   // x0 is forced to p0 on read so the mapping holds regardless of RAT contents.
   assign w_src0    = (in_decode.ARegAddrSrc0 == '0) ? '0 : r_rat[in_decode.ARegAddrSrc0];
   assign w_src1    = (in_decode.ARegAddrSrc1 == '0) ? '0 : r_rat[in_decode.ARegAddrSrc1];
   assign w_old_dst = (in_decode.ARegAddrDst  == '0) ? '0 : r_rat[in_decode.ARegAddrDst];

   always_comb begin
      w_next                = '0;
      w_next.immediate      = in_decode.immediate;
      w_next.ALUOp          = in_decode.ALUOp;
      w_next.ALUSrc         = in_decode.ALUSrc;
      w_next.RegWrite       = in_decode.RegWrite;
      w_next.MemRead        = in_decode.MemRead;
      w_next.MemWrite       = in_decode.MemWrite;
      w_next.MemtoReg       = in_decode.MemtoReg;
      w_next.PRegAddrSrc0   = w_src0;
      w_next.PRegAddrSrc1   = w_src1;
      w_next.PRegAddrDst    = w_alloc ? w_head    : '0;
      w_next.OldPRegAddrDst = w_alloc ? w_old_dst : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_AREGS; i++) r_rat[i] <= p_reg'(i);
      end else if (w_pop) begin
         r_rat[in_decode.ARegAddrDst] <= w_head;
      end
   end

   // Output register: load on accept, drain on consume, hold under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out       <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out       <= w_next;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_rename = r_out;

   free_list #(
      .DEPTH (NUM_PREGS - NUM_AREGS),
      .BASE  (NUM_AREGS)
   ) u_free_list (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (free_valid),
      .i_push_preg (free_preg),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (free_count)
   );

endmodule
